// File: rtl/dmni_mem_arbiter.sv
// ============================================================================
// dmni_mem_arbiter : round-robin share of the DMNI memory port, burst-capped
// Rev 1.0
// ============================================================================
`default_nettype none

module dmni_mem_arbiter #(
  parameter int N_REQ     = 3,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_REQ-1:0]     req_en_i,
  input  logic [N_REQ*4-1:0]   req_we_i,
  input  logic [N_REQ*32-1:0]  req_addr_i,
  input  logic [N_REQ*32-1:0]  req_data_i,
  output logic [N_REQ-1:0]     gnt_o,
  output logic [N_REQ-1:0]     rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 mem_en_o,
  output logic [3:0]           mem_we_o,
  output logic [31:0]          mem_addr_o,
  input  logic [31:0]          mem_data_i,
  output logic [31:0]          mem_data_o
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_CAP   = BW'(MAX_BURST);
  localparam logic [OW-1:0] OWNER_RESET = OW'(N_REQ - 1);

  logic [OW-1:0]    owner_q, owner_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [N_REQ-1:0] rvalid_q, rvalid_d;

  logic [OW-1:0]    sel;
  logic             sel_valid;
  logic [N_REQ-1:0] gnt;

  // Scan from farthest to nearest so the closest requester after owner_q wins;
  // owner_q itself is the farthest candidate (k == N_REQ).
  always_comb begin
    int            tmp;
    logic [OW-1:0] cand;
    sel       = owner_q;
    sel_valid = 1'b0;
    tmp       = 0;
    cand      = '0;
    if (rst_ni) begin
      if (req_en_i[owner_q] && (burst_q != '0) && (burst_q < BURST_CAP)) begin
        sel       = owner_q;
        sel_valid = 1'b1;
      end else begin
        for (int k = N_REQ; k >= 1; k--) begin
          tmp = int'(owner_q) + k;
          if (tmp >= N_REQ) tmp = tmp - N_REQ;
          cand = OW'(tmp);
          if (req_en_i[cand]) begin
            sel       = cand;
            sel_valid = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    mem_we_o   = '0;
    mem_addr_o = '0;
    mem_data_o = '0;
    rvalid_d   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i] = sel_valid && (sel == OW'(i));
      if (gnt[i]) begin
        mem_we_o   = mem_we_o   | req_we_i[i*4 +: 4];
        mem_addr_o = mem_addr_o | req_addr_i[i*32 +: 32];
        mem_data_o = mem_data_o | req_data_i[i*32 +: 32];
      end
      rvalid_d[i] = gnt[i] && (req_we_i[i*4 +: 4] == 4'h0);
    end
  end

  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    if (!sel_valid) begin
      burst_d = '0;
    end else if (sel != owner_q) begin
      owner_d = sel;
      burst_d = BW'(1);
    end else if (burst_q >= BURST_CAP) begin
      // lone owner hit the cap: restart the count, keep the port
      burst_d = BW'(1);
    end else begin
      burst_d = burst_q + BW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owner_q  <= OWNER_RESET;
      burst_q  <= '0;
      rvalid_q <= '0;
    end else begin
      owner_q  <= owner_d;
      burst_q  <= burst_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign gnt_o    = gnt;
  assign mem_en_o = sel_valid;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = mem_data_i;

endmodule

`default_nettype wire
